// File: rtl/pixel_write_master.sv
// Single-pixel Avalon-MM write master: takes one pixel request from the line
// engine, bounds-checks it against the frame buffer, writes it, and counts the outcome.
module pixel_write_master #(
   parameter int unsigned FB_BYTES = 153600,
   parameter int unsigned STATS_W  = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Draw,
   input  logic [31:0]        Pixel_Address,
   input  logic [15:0]        Color,
   input  logic [31:0]        Base_Addr,
   output logic               Write_Finish,
   output logic               Busy,
   output logic [31:0]        master_address,
   output logic               master_write,
   output logic [15:0]        master_writedata,
   output logic [1:0]         master_byteenable,
   input  logic               master_waitrequest,
   input  logic               Stats_Clear,
   output logic [STATS_W-1:0] Pixel_Count,
   output logic [STATS_W-1:0] Drop_Count,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q;
   logic [15:0] color_q;
   logic        accept;
   logic        in_range;
   logic        pix_inc, drop_inc;
   logic [32:0] pa_ext, base_ext, limit_ext;

   // 33-bit compare so a base near the top of the address map cannot wrap.
   assign pa_ext    = {1'b0, Pixel_Address};
   assign base_ext  = {1'b0, Base_Addr};
   assign limit_ext = base_ext + 33'(FB_BYTES);
   assign in_range  = (pa_ext >= base_ext) && (pa_ext < limit_ext) && !Pixel_Address[0];
   assign accept    = (state_q == IDLE) && Draw;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= Pixel_Address;
            color_q <= Color;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      pix_inc  = 1'b0;
      drop_inc = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (Draw) begin
               if (in_range) begin
                  state_d = WRITE;
               end else begin
                  state_d  = FINISH;
                  drop_inc = 1'b1;
               end
            end
         end
         WRITE: begin
            if (!master_waitrequest) begin
               state_d = FINISH;
               pix_inc = 1'b1;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake: a beat is offered while master_write=1 and completes on the
   // first rising edge where master_waitrequest=0; all bus fields hold until then.
   assign master_write      = (state_q == WRITE);
   assign master_address    = master_write ? addr_q  : 32'd0;
   assign master_writedata  = master_write ? color_q : 16'd0;
   assign master_byteenable = master_write ? 2'b11   : 2'b00;
   assign Write_Finish      = (state_q == FINISH);
   assign Busy              = (state_q != IDLE);
   assign dbg_state         = state_q;

   // Saturating counters; clear wins over a same-cycle increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Pixel_Count <= '0;
         Drop_Count  <= '0;
      end else if (Stats_Clear) begin
         Pixel_Count <= '0;
         Drop_Count  <= '0;
      end else begin
         if (pix_inc && (Pixel_Count != {STATS_W{1'b1}}))
            Pixel_Count <= Pixel_Count + 1'b1;
         if (drop_inc && (Drop_Count != {STATS_W{1'b1}}))
            Drop_Count <= Drop_Count + 1'b1;
      end
   end

endmodule
